// File: rtl/bitonic_sorter_pkg.sv
// Shared constants and elaboration-time helpers for the bitonic sorter and its
// compare-exchange cell.
package bitonic_sorter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_KEY_WIDTH  = 32;
    localparam int DEFAULT_LOG_N      = 3;

    // Number of compare-exchange layers in a full bitonic network of 2**log_n records.
    function automatic int stage_count(input int log_n);
        return log_n * (log_n + 1) / 2;
    endfunction

    function automatic int rec_lsb(input int k, input int data_width);
        return k * data_width;
    endfunction

    // Layer number of merge step at partner distance 2**q inside build phase p.
    function automatic int layer_index(input int p, input int q);
        return p * (p + 1) / 2 + (p - q);
    endfunction

endpackage

// File: rtl/bitonic_sorter_cas_dir.sv
// Combinational compare-exchange of two records on an unsigned key field;
// equal keys are never swapped so paired values stay untouched.
module cas_dir
    import bitonic_sorter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int KEY_WIDTH  = DEFAULT_KEY_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  descend,
    output logic [DATA_WIDTH-1:0] first,
    output logic [DATA_WIDTH-1:0] second
);

    logic [KEY_WIDTH-1:0] key_a;
    logic [KEY_WIDTH-1:0] key_b;
    logic                 swap;

    assign key_a  = a[DATA_WIDTH-1 -: KEY_WIDTH];
    assign key_b  = b[DATA_WIDTH-1 -: KEY_WIDTH];
    assign swap   = descend ? (key_a < key_b) : (key_a > key_b);
    assign first  = swap ? b : a;
    assign second = swap ? a : b;

endmodule

// File: rtl/bitonic_sorter.sv
// Fully pipelined bitonic sorting network: one registered compare-exchange layer
// per step, all layers advancing together under a single global enable.
module bitonic_sorter
    import bitonic_sorter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int KEY_WIDTH  = DEFAULT_KEY_WIDTH,
    parameter int LOG_N      = DEFAULT_LOG_N
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic                              i_descend,
    input  logic [(1<<LOG_N)*DATA_WIDTH-1:0]  i_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [(1<<LOG_N)*DATA_WIDTH-1:0]  o_data,
    output logic                              o_descend
);

    localparam int N = 1 << LOG_N;
    localparam int S = stage_count(LOG_N);

    logic [DATA_WIDTH-1:0] layer_data [S][N];
    logic [S-1:0]          layer_valid;
    logic [S-1:0]          layer_desc;

    logic [DATA_WIDTH-1:0] net_in  [S][N];
    logic [DATA_WIDTH-1:0] net_out [S][N];
    logic [S-1:0]          in_desc;
    logic                  en;

    // Reset forces the enable high so upstream never sees a stall while clearing.
    assign en      = !o_valid || i_ready || i_rst;
    assign o_ready = en;

    for (genvar l = 0; l < S; l++) begin : g_layer_in
        if (l == 0) begin : g_first
            assign in_desc[0] = i_descend;
            for (genvar k = 0; k < N; k++) begin : g_rec
                assign net_in[0][k] = i_data[rec_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
            end
        end else begin : g_rest
            assign in_desc[l] = layer_desc[l-1];
            for (genvar k = 0; k < N; k++) begin : g_rec
                assign net_in[l][k] = layer_data[l-1][k];
            end
        end
    end

    // Phase p merges blocks of 2**(p+1); bit p+1 of the index picks the block direction.
    for (genvar p = 0; p < LOG_N; p++) begin : g_phase
        for (genvar qq = 0; qq <= p; qq++) begin : g_step
            localparam int Q = p - qq;
            localparam int L = layer_index(p, Q);
            for (genvar i = 0; i < N; i++) begin : g_pair
                if (((i >> Q) % 2) == 0) begin : g_cas
                    localparam int J        = i + (1 << Q);
                    localparam bit SUB_DESC = ((i >> (p + 1)) % 2) == 1;
                    cas_dir #(
                        .DATA_WIDTH (DATA_WIDTH),
                        .KEY_WIDTH  (KEY_WIDTH)
                    ) u_cas (
                        .a       (net_in[L][i]),
                        .b       (net_in[L][J]),
                        .descend (SUB_DESC ^ in_desc[L]),
                        .first   (net_out[L][i]),
                        .second  (net_out[L][J])
                    );
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            layer_valid <= '0;
            layer_desc  <= '0;
            for (int l = 0; l < S; l++) begin
                for (int k = 0; k < N; k++) begin
                    layer_data[l][k] <= '0;
                end
            end
        end else if (en) begin
            layer_valid[0] <= i_valid;
            for (int l = 1; l < S; l++) begin
                layer_valid[l] <= layer_valid[l-1];
            end
            for (int l = 0; l < S; l++) begin
                layer_desc[l] <= in_desc[l];
                for (int k = 0; k < N; k++) begin
                    layer_data[l][k] <= net_out[l][k];
                end
            end
        end
    end

    assign o_valid   = layer_valid[S-1];
    assign o_descend = layer_desc[S-1];
    for (genvar k = 0; k < N; k++) begin : g_out
        assign o_data[rec_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = layer_data[S-1][k];
    end

endmodule
